seq_priority_encoder: RTL and testbench

//  Sequential encoder, the inverse of the 2-to-4 decoder: accepts an N-bit request

---
 rtl/seq_priority_encoder_if.sv | 37 +++
 rtl/seq_priority_encoder.sv | 86 ++++++++
 tb/tb_seq_priority_encoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seq_priority_encoder_if.sv
// Valid/ready handshake bundle for the sequential priority encoder.
// The slave modport is the encoder's view; the master modport is the environment's view.
interface seq_priority_encoder_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
);
    logic [N-1:0] req_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] code_out;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         zero_pulse;

    modport slave (
        input  req_in,
        input  in_valid,
        output in_ready,
        output code_out,
        output out_last,
        output out_valid,
        input  out_ready,
        output zero_pulse
    );

    modport master (
        output req_in,
        output in_valid,
        input  in_ready,
        input  code_out,
        input  out_last,
        input  out_valid,
        output out_ready,
        input  zero_pulse
    );
endinterface

// File: rtl/seq_priority_encoder.sv
// Accepts a multi-hot request vector and emits the index of each set bit,
// highest first, one code per output handshake.
module seq_priority_encoder #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_priority_encoder_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ENCODE = 1'b1
    } state_e;

    state_e       state_q;
    logic [N-1:0] pend_q;
    logic         zero_pulse_q;

    logic [W-1:0] top_idx;
    logic [N-1:0] top_onehot;
    logic         single_bit;
    logic         in_fire;
    logic         out_fire;

    // Highest set bit of the pending vector; later iterations win.
    always_comb begin
        top_idx    = '0;
        top_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pend_q[i]) begin
                top_idx    = W'(i);
                top_onehot = N'(1) << i;
            end
        end
    end

    // Exactly one bit left means this code closes the vector.
    assign single_bit = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);

    assign in_fire  = (state_q == IDLE) && bus.in_valid;
    assign out_fire = (state_q == ENCODE) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            zero_pulse_q <= 1'b0;
        end else begin
            zero_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        if (bus.req_in != '0) begin
                            pend_q  <= bus.req_in;
                            state_q <= ENCODE;
                        end else begin
                            zero_pulse_q <= 1'b1;
                        end
                    end
                end
                ENCODE: begin
                    if (out_fire) begin
                        pend_q <= pend_q & ~top_onehot;
                        if (single_bit) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pend_q  <= '0;
                end
            endcase
        end
    end

    // Outputs decode from registers only, gated so idle codes read as zero.
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == ENCODE);
    assign bus.code_out   = (state_q == ENCODE) ? top_idx : '0;
    assign bus.out_last   = (state_q == ENCODE) && single_bit;
    assign bus.zero_pulse = zero_pulse_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder (N=4, W=2) with hand-computed expectations.
module tb_seq_priority_encoder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_priority_encoder_if #(.N(N), .W(W)) bus ();

    seq_priority_encoder #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [W-1:0] c,
                             input logic l, input logic rdy);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".code"},  32'(bus.code_out),  32'(c));
        check({tag, ".last"},  32'(bus.out_last),  32'(l));
        check({tag, ".ready"}, 32'(bus.in_ready),  32'(rdy));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // 1: reset held with a full request pending
        rst_n         = 1'b0;
        bus.req_in    = 4'hF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_out("rst0", 1'b0, 2'd0, 1'b0, 1'b1);
        check("rst0.zp", 32'(bus.zero_pulse), 32'd0);
        tick();
        tick();
        check_out("rst1", 1'b0, 2'd0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        check_out("rel", 1'b0, 2'd0, 1'b0, 1'b1);

        // 2: 1010 streamed with out_ready high
        bus.req_in   = 4'b1010;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_out("t2c1", 1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        check_out("t2c2", 1'b1, 2'd1, 1'b1, 1'b0);
        tick();
        check_out("t2c3", 1'b0, 2'd0, 1'b0, 1'b1);

        // 3: single bit under backpressure
        bus.req_in    = 4'b0100;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_out($sformatf("t3hold%0d", i), 1'b1, 2'd2, 1'b1, 1'b0);
            tick();
        end
        check_out("t3hold3", 1'b1, 2'd2, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check_out("t3done", 1'b0, 2'd0, 1'b0, 1'b1);

        // 4: all-zero vector gives a single zero pulse
        bus.req_in   = 4'b0000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t4.zp1", 32'(bus.zero_pulse), 32'd1);
        check_out("t4a", 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        check("t4.zp2", 32'(bus.zero_pulse), 32'd0);
        check_out("t4b", 1'b0, 2'd0, 1'b0, 1'b1);

        // 5: 1111 with a second vector offered during ENCODE
        bus.req_in   = 4'b1111;
        bus.in_valid = 1'b1;
        tick();
        bus.req_in = 4'b0001;
        check_out("t5c3", 1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        check_out("t5c2", 1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        check_out("t5c1", 1'b1, 2'd1, 1'b0, 1'b0);
        tick();
        check_out("t5c0", 1'b1, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("t5idle", 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check_out("t5second", 1'b1, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("t5end", 1'b0, 2'd0, 1'b0, 1'b1);

        // 6: reset after the first code of 1011
        bus.req_in   = 4'b1011;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_out("t6c3", 1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        check_out("t6c1", 1'b1, 2'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_out("t6rst", 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("t6post%0d", i), 1'b0, 2'd0, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
